// File: rtl/pipelined_core_pkg.sv
// Shared definitions for pipelined_core_p: opcode encodings, instruction field
// positions and small decode helpers.
package pipelined_core_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_ADDI  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int OPC_LSB = 29;
    localparam int RS_LSB  = 25;
    localparam int RT_LSB  = 21;
    localparam int RD_LSB  = 17;
    localparam int IMM_LSB = 0;

    // Widest datapath the sign-extension helper covers; callers cast down.
    localparam int SEXT_W = 64;

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [15:0] imm;
    } if_id_t;

    function automatic logic [SEXT_W-1:0] sext16(input logic [15:0] v);
        return {{(SEXT_W-16){v[15]}}, v};
    endfunction

    function automatic logic op_writes_rd(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_LOAD) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/pipelined_core_p_alu.sv
// Combinational EX unit: ALU result and wrapped data-memory word address.
module pipelined_alu
    import pipelined_core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DA_W   = 4
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DA_W-1:0]   addr_o
);

    logic [DATA_W-1:0] ea;

    // rs+imm serves both ADDI and the LOAD/STORE effective address.
    assign ea     = opa_i + imm_i;
    assign addr_o = ea[DA_W-1:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = opa_i + opb_i;
            OP_SUB:  result_o = opa_i - opb_i;
            OP_AND:  result_o = opa_i & opb_i;
            OP_ADDI: result_o = ea;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_core_p.sv
// Four-stage (IF, ID, EX, WB) core with full forwarding, program-load port and
// retire observation. Memories and the regfile live here; the ALU is separate.
module pipelined_core_p
    import pipelined_core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    localparam int IA_W      = $clog2(IMEM_DEPTH),
    localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_we,
    input  logic [IA_W-1:0]   imem_addr,
    input  logic [31:0]       imem_wdata,
    input  logic [3:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [31:0]       pc_o,
    output logic              halted,
    output logic              wb_valid,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    logic [31:0]       imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
    logic [DATA_W-1:0] rf_q   [16];

    logic [31:0]       pc_q, pc_d;
    logic              halted_q;
    logic [IA_W-1:0]   fetch_idx, fetch_next;

    if_id_t            if_id_q;

    logic              id_ex_valid_q, id_ex_we_q;
    logic [2:0]        id_ex_op_q;
    logic [3:0]        id_ex_rd_q;
    logic [DATA_W-1:0] id_ex_a_q, id_ex_b_q, id_ex_imm_q;

    logic              ex_wb_we_q;
    logic [3:0]        ex_wb_rd_q;
    logic [DATA_W-1:0] ex_wb_data_q;

    logic [DATA_W-1:0] id_a, id_b, id_imm;
    logic              id_we;
    logic [DATA_W-1:0] alu_result, ex_result;
    logic [DA_W-1:0]   mem_addr;
    logic              ex_store, ex_halt;

    assign fetch_idx  = pc_q[2 +: IA_W];
    assign fetch_next = fetch_idx + IA_W'(1);
    assign pc_d       = {{(32-IA_W-2){1'b0}}, fetch_next, 2'b00};

    assign id_imm = DATA_W'(sext16(if_id_q.imm));
    assign id_we  = if_id_q.valid && op_writes_rd(if_id_q.op) && (if_id_q.rd != 4'd0);

    // The EX result (including LOAD data) beats the WB register, which beats
    // the regfile; the we flags already exclude r0 and invalid slots.
    always_comb begin
        id_a = rf_q[if_id_q.rs];
        if (id_ex_we_q && (id_ex_rd_q == if_id_q.rs))
            id_a = ex_result;
        else if (ex_wb_we_q && (ex_wb_rd_q == if_id_q.rs))
            id_a = ex_wb_data_q;

        id_b = rf_q[if_id_q.rt];
        if (id_ex_we_q && (id_ex_rd_q == if_id_q.rt))
            id_b = ex_result;
        else if (ex_wb_we_q && (ex_wb_rd_q == if_id_q.rt))
            id_b = ex_wb_data_q;
    end

    pipelined_alu #(
        .DATA_W (DATA_W),
        .DA_W   (DA_W)
    ) u_alu (
        .op_i     (id_ex_op_q),
        .opa_i    (id_ex_a_q),
        .opb_i    (id_ex_b_q),
        .imm_i    (id_ex_imm_q),
        .result_o (alu_result),
        .addr_o   (mem_addr)
    );

    assign ex_result = (id_ex_op_q == OP_LOAD) ? dmem_q[mem_addr] : alu_result;
    assign ex_store  = id_ex_valid_q && (id_ex_op_q == OP_STORE);
    assign ex_halt   = id_ex_valid_q && (id_ex_op_q == OP_HALT);

    always_ff @(posedge clk) begin
        if (imem_we)
            imem_q[imem_addr] <= imem_wdata;
    end

    // A store caught by reset is squashed like every other in-flight op.
    always_ff @(posedge clk) begin
        if (!rst && ex_store)
            dmem_q[mem_addr] <= id_ex_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            halted_q      <= 1'b0;
            if_id_q       <= '0;
            id_ex_valid_q <= 1'b0;
            id_ex_we_q    <= 1'b0;
            id_ex_op_q    <= OP_NOP;
            id_ex_rd_q    <= '0;
            id_ex_a_q     <= '0;
            id_ex_b_q     <= '0;
            id_ex_imm_q   <= '0;
            ex_wb_we_q    <= 1'b0;
            ex_wb_rd_q    <= '0;
            ex_wb_data_q  <= '0;
            for (int i = 0; i < 16; i++)
                rf_q[i] <= '0;
        end else begin
            if (ex_wb_we_q)
                rf_q[ex_wb_rd_q] <= ex_wb_data_q;

            ex_wb_we_q   <= id_ex_we_q;
            ex_wb_rd_q   <= id_ex_rd_q;
            ex_wb_data_q <= ex_result;

            if (ex_halt || halted_q) begin
                halted_q      <= 1'b1;
                if_id_q.valid <= 1'b0;
                id_ex_valid_q <= 1'b0;
                id_ex_we_q    <= 1'b0;
            end else begin
                pc_q          <= pc_d;
                if_id_q.valid <= 1'b1;
                if_id_q.op    <= imem_q[fetch_idx][OPC_LSB +: 3];
                if_id_q.rs    <= imem_q[fetch_idx][RS_LSB +: 4];
                if_id_q.rt    <= imem_q[fetch_idx][RT_LSB +: 4];
                if_id_q.rd    <= imem_q[fetch_idx][RD_LSB +: 4];
                if_id_q.imm   <= imem_q[fetch_idx][IMM_LSB +: 16];
                id_ex_valid_q <= if_id_q.valid;
                id_ex_we_q    <= id_we;
                id_ex_op_q    <= if_id_q.op;
                id_ex_rd_q    <= if_id_q.rd;
                id_ex_a_q     <= id_a;
                id_ex_b_q     <= id_b;
                id_ex_imm_q   <= id_imm;
            end
        end
    end

    assign dbg_rdata = rf_q[dbg_raddr];
    assign pc_o      = pc_q;
    assign halted    = halted_q;
    assign wb_valid  = ex_wb_we_q;
    assign wb_rd     = ex_wb_rd_q;
    assign wb_data   = ex_wb_data_q;

endmodule

// File: doc/pipelined_core_p.md
# pipelined_core_p

Parametrised successor of the team's 4-stage (IF, ID, EX, WB) pipelined core. Adds configurable data width and memory depths, valid-tracked pipeline registers, full forwarding (zero-stall RAW resolution), immediate/store/halt instructions, a program-load port and a retire/debug observation port. It is the standalone CPU datapath used by the pipeline test harnesses.

## Interface
- DATA_W, 32, datapath and register width; must be ≥ 16.
- IMEM_DEPTH, 16, instruction words; power of two.
- DMEM_DEPTH, 16, data words; power of two.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_we  in  1  program-load write strobe.
- imem_addr  in  clog2(IMEM_DEPTH)  program-load word index.
- imem_wdata  in  32  instruction word.
- dbg_raddr  in  4  debug register index.
- dbg_rdata  out  DATA_W  combinational regfile[dbg_raddr].
- pc_o  out  32  current fetch PC (byte address).
- halted  out  1  core stopped by HALT.
- wb_valid  out  1  an instruction with register write is in WB this cycle.
- wb_rd  out  4  its destination.
- wb_data  out  DATA_W  its result.

## Operation
- Instruction format: opcode[31:29], rs[28:25], rt[24:21], rd[20:17], bit 16 reserved (0), imm[15:0] sign-extended to DATA_W.
- Opcodes: 000 ADD rd=rs+rt; 001 SUB rd=rs−rt; 010 AND rd=rs&rt; 011 LOAD rd=dmem[rs+imm]; 100 STORE dmem[rs+imm]=rt; 101 ADDI rd=rs+imm; 110 NOP; 111 HALT.
- Arithmetic modulo 2^DATA_W; no flags. Data address = low clog2(DMEM_DEPTH) bits of rs+imm (wraps).
- r0 reads as 0; writes to r0 are dropped (no wb_valid).
- Fetch index = PC[2 +: clog2(IMEM_DEPTH)]; PC += 4 per cycle, wrapping over the IMEM.
- Each pipeline register carries a valid bit; invalid slots perform no write, store, or halt.
- ID operand forwarding, priority: EX-stage ALU result (valid, writes rd, rd==src, rd≠0) > EX/WB register > regfile. No stalls.
- STORE writes dmem at the end of its EX cycle; a following LOAD sees the new value.
- HALT in EX: at that edge halted←1, IF/ID and ID/EX valids cleared, PC frozen. Older instructions (in EX/WB) retire; no further fetch. HALT produces no wb_valid. Only rst clears halted.
- imem_we accepted any cycle, including while halted or in reset; the write is visible to a fetch on the next edge. Simultaneous write/fetch of the same word fetches the old word.
- Reset: PC=0, all valids 0, halted=0, regfile cleared to 0, wb_valid=0, wb_rd=0, wb_data=0, pc_o=0. IMEM and DMEM are not cleared. Reset mid-program squashes all in-flight instructions; none write.

## Timing
- Instruction fetched at edge k: ID/EX at k+1, EX/WB at k+2 (wb_* valid in the following cycle), regfile written at k+3.
- First post-reset instruction (imem[0]) reaches wb_valid 3 cycles after rst falls.
- Throughput: one instruction per cycle, including back-to-back dependent ALU/LOAD.
- halted rises the cycle after HALT enters EX; the last wb_valid is that same cycle.
- dbg_rdata is combinational and shows pre-write contents during the WB cycle.

## Structure
- Package pipelined_core_pkg: opcode localparams, instruction field bit positions, sign-extension function.
- Sub-module pipelined_alu: combinational EX unit (opcode, opA, opB, imm → result, mem address). Regfile, memories, forwarding and control stay in the top.

## Test plan
- Reset/fill: after rst, load ADDI r1=r0+5, ADDI r2=r0+7, ADD r3=r1+r2, HALT → wb sequence (1,5), (2,7), (3,12); halted=1; dbg r3=12.
- Forwarding: SUB r4=r3−r1 immediately after ADD r3 → r4=7 with no bubble (wb_valid on consecutive cycles).
- Memory: ADDI r5=9; STORE dmem[r0+3]=r5; LOAD r6=dmem[r0+3] back-to-back → r6=9. LOAD with addr 19 (DEPTH 16) reads word 3.
- r0 and wrap: ADDI r0=r0+1 → no wb_valid, r0 reads 0. 16 NOPs without HALT → PC wraps to 0 and pc_o=0x40→0 pattern is replaced by re-fetch of imem[0].
- Halt squash: HALT followed by ADDI r7=1 → r7 stays 0; PC frozen; rst then clears halted and restarts at PC 0.
- Reset mid-op: assert rst while ADD is in EX → no wb_valid, regfile all 0, outputs at reset values.
